// File: rtl/inst_encoder_if.sv
// Request/response bus of the MIPS32 instruction encoder.
// The master issues mnemonic requests and drains the encoded words.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_sa;
  logic [25:0] in_imm;
  logic [2:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_sa, in_imm, in_sel, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_sa, in_imm, in_sel, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/inst_encoder.sv
// Streaming MIPS32 assembler: packs mnemonic+operand requests into instruction
// words, tags them with a running load address and queues them in a FIFO.
module inst_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  inst_encoder_if.slave            bus,
  output logic                     illegal,
  output logic [CNT_W-1:0]         illegal_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   pc;
  logic [31:0]   word_c;
  logic          legal_c;
  logic          accept_c;
  logic          push_c;
  logic          pop_c;
  logic          out_valid_c;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    sa;
  logic [15:0]   imm16;

  function automatic logic [31:0] r_fmt(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                        input logic [4:0] f_rd, input logic [4:0] f_sa,
                                        input logic [5:0] funct);
    return {6'h00, f_rs, f_rt, f_rd, f_sa, funct};
  endfunction

  function automatic logic [31:0] i_fmt(input logic [5:0] opc, input logic [4:0] f_rs,
                                        input logic [4:0] f_rt, input logic [15:0] imm);
    return {opc, f_rs, f_rt, imm};
  endfunction

  assign rs    = bus.in_rs;
  assign rt    = bus.in_rt;
  assign rd    = bus.in_rd;
  assign sa    = bus.in_sa;
  assign imm16 = bus.in_imm[15:0];

  // Mnemonic ID to instruction word; unused fields are forced to zero.
  always_comb begin
    word_c  = '0;
    legal_c = 1'b1;
    case (bus.in_op)
      6'd0:  word_c = '0;
      6'd1:  word_c = r_fmt(rs, rt, rd, 5'd0, 6'h20);
      6'd2:  word_c = r_fmt(rs, rt, rd, 5'd0, 6'h21);
      6'd3:  word_c = r_fmt(rs, rt, rd, 5'd0, 6'h22);
      6'd4:  word_c = r_fmt(rs, rt, rd, 5'd0, 6'h23);
      6'd5:  word_c = r_fmt(rs, rt, rd, 5'd0, 6'h24);
      6'd6:  word_c = r_fmt(rs, rt, rd, 5'd0, 6'h25);
      6'd7:  word_c = r_fmt(rs, rt, rd, 5'd0, 6'h26);
      6'd8:  word_c = r_fmt(rs, rt, rd, 5'd0, 6'h27);
      6'd9:  word_c = r_fmt(rs, rt, rd, 5'd0, 6'h2A);
      6'd10: word_c = r_fmt(rs, rt, rd, 5'd0, 6'h2B);
      6'd11: word_c = r_fmt(5'd0, rt, rd, sa, 6'h00);
      6'd12: word_c = r_fmt(5'd0, rt, rd, sa, 6'h02);
      6'd13: word_c = r_fmt(5'd0, rt, rd, sa, 6'h03);
      6'd14: word_c = r_fmt(rs, rt, rd, 5'd0, 6'h04);
      6'd15: word_c = r_fmt(rs, rt, rd, 5'd0, 6'h06);
      6'd16: word_c = r_fmt(rs, rt, rd, 5'd0, 6'h07);
      6'd17: word_c = r_fmt(rs, 5'd0, 5'd0, 5'd0, 6'h08);
      6'd18: word_c = r_fmt(rs, 5'd0, rd, 5'd0, 6'h09);
      6'd19: word_c = r_fmt(5'd0, 5'd0, rd, 5'd0, 6'h10);
      6'd20: word_c = r_fmt(rs, 5'd0, 5'd0, 5'd0, 6'h11);
      6'd21: word_c = r_fmt(5'd0, 5'd0, rd, 5'd0, 6'h12);
      6'd22: word_c = r_fmt(rs, 5'd0, 5'd0, 5'd0, 6'h13);
      6'd23: word_c = r_fmt(rs, rt, 5'd0, 5'd0, 6'h18);
      6'd24: word_c = r_fmt(rs, rt, 5'd0, 5'd0, 6'h19);
      6'd25: word_c = r_fmt(rs, rt, 5'd0, 5'd0, 6'h1A);
      6'd26: word_c = r_fmt(rs, rt, 5'd0, 5'd0, 6'h1B);
      6'd27: word_c = 32'h0000000C;
      6'd28: word_c = 32'h0000000D;
      6'd32: word_c = i_fmt(6'h08, rs, rt, imm16);
      6'd33: word_c = i_fmt(6'h09, rs, rt, imm16);
      6'd34: word_c = i_fmt(6'h0A, rs, rt, imm16);
      6'd35: word_c = i_fmt(6'h0B, rs, rt, imm16);
      6'd36: word_c = i_fmt(6'h0C, rs, rt, imm16);
      6'd37: word_c = i_fmt(6'h0D, rs, rt, imm16);
      6'd38: word_c = i_fmt(6'h0E, rs, rt, imm16);
      6'd39: word_c = i_fmt(6'h0F, 5'd0, rt, imm16);
      6'd40: word_c = i_fmt(6'h04, rs, rt, imm16);
      6'd41: word_c = i_fmt(6'h05, rs, rt, imm16);
      6'd42: word_c = i_fmt(6'h06, rs, 5'd0, imm16);
      6'd43: word_c = i_fmt(6'h07, rs, 5'd0, imm16);
      6'd44: word_c = i_fmt(6'h01, rs, 5'b00001, imm16);
      6'd45: word_c = i_fmt(6'h01, rs, 5'b10001, imm16);
      6'd46: word_c = i_fmt(6'h01, rs, 5'b00000, imm16);
      6'd47: word_c = i_fmt(6'h01, rs, 5'b10000, imm16);
      6'd48: word_c = {6'h02, bus.in_imm};
      6'd49: word_c = {6'h03, bus.in_imm};
      6'd50: word_c = i_fmt(6'h20, rs, rt, imm16);
      6'd51: word_c = i_fmt(6'h24, rs, rt, imm16);
      6'd52: word_c = i_fmt(6'h21, rs, rt, imm16);
      6'd53: word_c = i_fmt(6'h25, rs, rt, imm16);
      6'd54: word_c = i_fmt(6'h23, rs, rt, imm16);
      6'd55: word_c = i_fmt(6'h28, rs, rt, imm16);
      6'd56: word_c = i_fmt(6'h29, rs, rt, imm16);
      6'd57: word_c = i_fmt(6'h2B, rs, rt, imm16);
      6'd58: word_c = 32'h42000018;
      6'd59: word_c = {6'h10, 5'b00000, rt, rd, 8'h00, bus.in_sel};
      6'd60: word_c = {6'h10, 5'b00100, rt, rd, 8'h00, bus.in_sel};
      default: legal_c = 1'b0;
    endcase
  end

  // Handshake decode; in_ready depends only on registered occupancy and flush.
  assign out_valid_c  = (level != '0);
  assign bus.in_ready = (level != LW'(DEPTH)) && !flush;
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign push_c       = accept_c && legal_c;
  assign pop_c        = out_valid_c && bus.out_ready && !flush;

  assign bus.out_valid = out_valid_c;
  assign bus.out_instr = out_valid_c ? mem[rd_ptr].instr : '0;
  assign bus.out_addr  = out_valid_c ? mem[rd_ptr].addr  : '0;

  // FIFO storage; contents are masked by out_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{instr: word_c, addr: pc};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      pc          <= BASE_ADDR;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      illegal <= accept_c && !legal_c;
      if (accept_c && !legal_c && (illegal_cnt != '1)) begin
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        pc     <= BASE_ADDR;
      end else begin
        if (push_c) begin
          wr_ptr <= wr_ptr + AW'(1);
          pc     <= pc + 32'd4;
        end
        if (pop_c) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push_c, pop_c})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: encoding vector table plus handshake,
// back-pressure, illegal-op, flush and async-reset sequences against a scoreboard.
module tb_inst_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hBFC00000;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [25:0] imm;
    logic [2:0]  sel;
    logic [31:0] exp;
    bit          legal;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        illegal;
  logic [15:0] illegal_cnt;
  logic [2:0]  level;

  inst_encoder_if bus();

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .bus         (bus),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt),
    .level       (level)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  ent_t        sb[$];
  int          mlevel;
  logic [31:0] mpc;
  logic [15:0] mcnt;
  bit          millegal;
  logic [31:0] cur_exp;
  bit          cur_legal;
  vec_t        tbl[25];
  vec_t        nop_v;
  vec_t        addiu_v;
  vec_t        addu_v;
  vec_t        bad_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT against model at negedge, advance model, step past posedge.
  task automatic step();
    ent_t e;
    bit   rdy;
    bit   acc;
    @(negedge clk);
    rdy = (mlevel < int'(DEPTH)) && !flush;
    check("in_ready", 32'(bus.in_ready), 32'(rdy));
    check("out_valid", 32'(bus.out_valid), 32'(mlevel != 0));
    check("level", 32'(level), 32'(mlevel));
    check("illegal", 32'(illegal), 32'(millegal));
    check("illegal_cnt", 32'(illegal_cnt), 32'(mcnt));
    if ((mlevel != 0) && bus.out_ready && !flush) begin
      e = sb.pop_front();
      check("out_instr", bus.out_instr, e.instr);
      check("out_addr", bus.out_addr, e.addr);
    end
    acc      = bus.in_valid && rdy;
    millegal = acc && !cur_legal;
    if (flush) begin
      sb.delete();
      mpc = BASE;
    end else if (acc) begin
      if (cur_legal) begin
        sb.push_back('{instr: cur_exp, addr: mpc});
        mpc = mpc + 32'd4;
      end else if (mcnt != 16'hFFFF) begin
        mcnt = mcnt + 16'd1;
      end
    end
    mlevel = sb.size();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1;
    bus.in_op    = v.op;
    bus.in_rs    = v.rs;
    bus.in_rt    = v.rt;
    bus.in_rd    = v.rd;
    bus.in_sa    = v.sa;
    bus.in_imm   = v.imm;
    bus.in_sel   = v.sel;
    cur_exp      = v.exp;
    cur_legal    = v.legal;
    step();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16 && mlevel != 0; k++) idle();
    if (mlevel != 0) begin
      failures++;
      $display("FAIL drain: %0d words left in FIFO", mlevel);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mlevel   = 0;
    mpc      = BASE;
    mcnt     = '0;
    millegal = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{6'd2,  5'd1,  5'd2,  5'd3,  5'd0, 26'h0000000, 3'd0, 32'h00221821, 1'b1};
    tbl[1]  = '{6'd33, 5'd0,  5'd8,  5'd0,  5'd0, 26'h0001234, 3'd0, 32'h24081234, 1'b1};
    tbl[2]  = '{6'd45, 5'd5,  5'd7,  5'd0,  5'd0, 26'h000FFFF, 3'd0, 32'h04B1FFFF, 1'b1};
    tbl[3]  = '{6'd58, 5'd3,  5'd4,  5'd5,  5'd6, 26'h3FFFFFF, 3'd7, 32'h42000018, 1'b1};
    tbl[4]  = '{6'd60, 5'd0,  5'd4,  5'd12, 5'd0, 26'h0000000, 3'd0, 32'h40846000, 1'b1};
    tbl[5]  = '{6'd0,  5'd31, 5'd31, 5'd31, 5'd31, 26'h3FFFFFF, 3'd7, 32'h00000000, 1'b1};
    tbl[6]  = '{6'd11, 5'd9,  5'd2,  5'd3,  5'd4, 26'h0000000, 3'd0, 32'h00021900, 1'b1};
    tbl[7]  = '{6'd17, 5'd31, 5'd5,  5'd6,  5'd0, 26'h0000000, 3'd0, 32'h03E00008, 1'b1};
    tbl[8]  = '{6'd39, 5'd7,  5'd1,  5'd0,  5'd0, 26'h000ABCD, 3'd0, 32'h3C01ABCD, 1'b1};
    tbl[9]  = '{6'd48, 5'd0,  5'd0,  5'd0,  5'd0, 26'h3FFFFFF, 3'd0, 32'h0BFFFFFF, 1'b1};
    tbl[10] = '{6'd59, 5'd0,  5'd8,  5'd12, 5'd0, 26'h0000000, 3'd1, 32'h40086001, 1'b1};
    tbl[11] = '{6'd57, 5'd29, 5'd31, 5'd0,  5'd0, 26'h0000010, 3'd0, 32'hAFBF0010, 1'b1};
    tbl[12] = '{6'd42, 5'd4,  5'd9,  5'd0,  5'd0, 26'h0008000, 3'd0, 32'h18808000, 1'b1};
    tbl[13] = '{6'd23, 5'd4,  5'd5,  5'd7,  5'd0, 26'h0000000, 3'd0, 32'h00850018, 1'b1};
    tbl[14] = '{6'd29, 5'd1,  5'd2,  5'd3,  5'd0, 26'h0000000, 3'd0, 32'h00000000, 1'b0};
    tbl[15] = '{6'd3,  5'd1,  5'd2,  5'd3,  5'd5, 26'h0000000, 3'd0, 32'h00221822, 1'b1};
    tbl[16] = '{6'd18, 5'd2,  5'd0,  5'd31, 5'd0, 26'h0000000, 3'd0, 32'h0040F809, 1'b1};
    tbl[17] = '{6'd46, 5'd3,  5'd0,  5'd0,  5'd0, 26'h0000004, 3'd0, 32'h04600004, 1'b1};
    tbl[18] = '{6'd27, 5'd1,  5'd1,  5'd1,  5'd1, 26'h0000000, 3'd0, 32'h0000000C, 1'b1};
    tbl[19] = '{6'd54, 5'd29, 5'd2,  5'd0,  5'd0, 26'h0000008, 3'd0, 32'h8FA20008, 1'b1};
    tbl[20] = '{6'd63, 5'd0,  5'd0,  5'd0,  5'd0, 26'h0000000, 3'd0, 32'h00000000, 1'b0};
    tbl[21] = '{6'd21, 5'd5,  5'd0,  5'd2,  5'd0, 26'h0000000, 3'd0, 32'h00001012, 1'b1};
    tbl[22] = '{6'd16, 5'd1,  5'd2,  5'd3,  5'd0, 26'h0000000, 3'd0, 32'h00221807, 1'b1};
    tbl[23] = '{6'd61, 5'd1,  5'd1,  5'd1,  5'd1, 26'h0000000, 3'd0, 32'h00000000, 1'b0};
    tbl[24] = '{6'd41, 5'd1,  5'd2,  5'd0,  5'd0, 26'h000FFFE, 3'd0, 32'h1422FFFE, 1'b1};
    nop_v   = '{6'd0,  5'd0,  5'd0,  5'd0,  5'd0, 26'h0, 3'd0, 32'h00000000, 1'b1};
    addiu_v = '{6'd33, 5'd0,  5'd8,  5'd0,  5'd0, 26'h0001234, 3'd0, 32'h24081234, 1'b1};
    addu_v  = '{6'd2,  5'd1,  5'd2,  5'd3,  5'd0, 26'h0, 3'd0, 32'h00221821, 1'b1};
    bad_v   = '{6'd29, 5'd0,  5'd0,  5'd0,  5'd0, 26'h0, 3'd0, 32'h00000000, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.in_rd     = '0;
    bus.in_sa     = '0;
    bus.in_imm    = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b0;
    cur_exp       = '0;
    cur_legal     = 1'b1;
    model_reset();

    // Reset state while resetn is held low.
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_addr", bus.out_addr, 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle();

    // Encoding table, consumer always ready.
    bus.out_ready = 1'b1;
    foreach (tbl[i]) drive(tbl[i]);
    drain();

    // Back-pressure: fill, stall, then concurrent push/pop, all from BASE.
    flush = 1'b1;
    idle();
    flush = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(nop_v);
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(nop_v);
    drain();

    // Illegal op while stalled, then a legal word takes the unchanged pc.
    bus.out_ready = 1'b0;
    drive(bad_v);
    drive(addu_v);
    bus.out_ready = 1'b1;
    drain();

    // Flush with words queued and a pop attempted in the same cycle.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(addiu_v);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    drive(addu_v);
    flush = 1'b0;
    drive(addu_v);
    drain();

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    drive(addiu_v);
    drive(addu_v);
    drive(bad_v);
    bus.in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_instr", bus.out_instr, 32'd0);
    check("arst_out_addr", bus.out_addr, 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_illegal", 32'(illegal), 32'd0);
    check("arst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(addu_v);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming MIPS32 instruction assembler, the inverse of the debug instruction decoder.
- Accepts a mnemonic ID plus operand fields over a valid/ready handshake and packs them into 32-bit instruction words.
- Tags each word with a running load address and buffers it in an output FIFO.
- Used by test-program loaders and self-check benches to produce instruction-RAM images for the SoC core.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, ≥2).
- BASE_ADDR, 32'hBFC00000, address of the first emitted word after reset or flush.
- CNT_W, 16, width of the illegal-op counter.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO and address.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  6  mnemonic ID (table below).
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_sa  in  5  shift amount.
- in_imm  in  26  [15:0] immediate/offset; [25:0] jump target.
- in_sel  in  3  CP0 select.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops head when out_valid && out_ready.
- out_instr  out  32  encoded word at FIFO head.
- out_addr  out  32  address of that word.
- illegal  out  1  one-cycle pulse: unsupported in_op was accepted.
- illegal_cnt  out  CNT_W  saturating count of illegal requests.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (resetn=0, async): FIFO empty, out_valid=0, out_instr=0, out_addr=0, level=0, pc=BASE_ADDR, illegal=0, illegal_cnt=0. Any request in flight is discarded.
- in_ready = (level < DEPTH) && !flush. It is derived from registered state only; there is no pass-through path from out_ready.
- Encoding is combinational from the in_* fields. On an accepted legal op, {word, pc} is written at the clock edge and pc increments by 4, wrapping mod 2^32.
- Latency is 1 cycle: a word accepted at edge N into an empty FIFO gives out_valid=1 after edge N.
- Push and pop in the same cycle: level is unchanged and order is preserved. Pop on empty is ignored.
- Illegal op (any ID not in the table): nothing is written, pc is unchanged, illegal pulses for 1 cycle, and illegal_cnt increments, saturating at all-ones.
- flush=1: FIFO emptied, pc=BASE_ADDR, any pop that cycle is ignored, illegal_cnt is kept.
- Field packing uses standard MIPS32 layouts. Fields a format does not use are forced to 0.
  - R-type: {000000, rs, rt, rd, sa, funct}.
    - Shifts SLL/SRL/SRA use rt, rd, sa with rs=0.
    - SLLV/SRLV/SRAV use rs, rt, rd.
    - JR uses rs. JALR uses rs, rd.
    - MFHI/MFLO use rd. MTHI/MTLO use rs.
    - MULT/MULTU/DIV/DIVU use rs, rt.
    - SYSCALL and BREAK have code=0.
  - I-type: {opcode, rs, rt, imm[15:0]}.
    - LUI has rs=0.
    - BLEZ/BGTZ have rt=0.
  - REGIMM: {000001, rs, code, imm[15:0]}, with BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001.
  - J/JAL: {opcode, imm[25:0]}.
  - NOP = 32'h0. ERET = 32'h42000018.
  - MFC0: {010000, 00000, rt, rd, 8'b0, sel}. MTC0: same layout with rs=00100.
- ID table (decimal):
  - 0 NOP, 1 ADD, 2 ADDU, 3 SUB, 4 SUBU, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLTU
  - 11 SLL, 12 SRL, 13 SRA, 14 SLLV, 15 SRLV, 16 SRAV
  - 17 JR, 18 JALR, 19 MFHI, 20 MTHI, 21 MFLO, 22 MTLO
  - 23 MULT, 24 MULTU, 25 DIV, 26 DIVU, 27 SYSCALL, 28 BREAK
  - 32 ADDI, 33 ADDIU, 34 SLTI, 35 SLTIU, 36 ANDI, 37 ORI, 38 XORI, 39 LUI
  - 40 BEQ, 41 BNE, 42 BLEZ, 43 BGTZ, 44 BGEZ, 45 BGEZAL, 46 BLTZ, 47 BLTZAL, 48 J, 49 JAL
  - 50 LB, 51 LBU, 52 LH, 53 LHU, 54 LW, 55 SB, 56 SH, 57 SW
  - 58 ERET, 59 MFC0, 60 MTC0
  - 29–31 and 61–63 are illegal.

Test Plan:
- ADDU (op 2), rs=1, rt=2, rd=3 -> out_instr=0x00221821, out_addr=0xBFC00000, out_valid 1 cycle after accept.
- ADDIU (op 33), rs=0, rt=8, imm=0x1234, then BGEZAL (op 45), rs=5, imm=0xFFFF -> 0x24081234 @0xBFC00000, then 0x04B1FFFF @0xBFC00004.
- DEPTH=4, out_ready=0, 6 back-to-back NOPs -> in_ready=0 after 4 accepts, level=4. Release out_ready -> addresses 0xBFC00000–0xBFC0000C in order. Simultaneous push/pop keeps level constant.
- op 29 accepted -> illegal pulse for 1 cycle, illegal_cnt=1, level unchanged, next legal word gets the unchanged pc.
- ERET (op 58) then MTC0 (op 60), rt=4, rd=12 -> 0x42000018, then 0x40846000.
- 3 words queued, then flush -> level=0, out_valid=0, next word at 0xBFC00000. Assert resetn low mid-stream -> all outputs 0 immediately, illegal_cnt=0.
